// File: rtl/bus_arbiter_if.sv
// Request/grant signal bundle between the two bus masters and the arbiter.
// The arbiter takes the slave modport; the master-side logic (or a bench) takes master.
interface bus_arbiter_if;
    logic req_m1;
    logic req_m2;
    logic master_select;
    logic grant_m1;
    logic grant_m2;
    logic bus_busy;
    logic preempt;

    modport master (
        output req_m1, req_m2,
        input  master_select, grant_m1, grant_m2, bus_busy, preempt
    );

    modport slave (
        input  req_m1, req_m2,
        output master_select, grant_m1, grant_m2, bus_busy, preempt
    );
endinterface

// File: rtl/bus_arbiter.sv
// Two-master round-robin bus arbiter with a hold-time limit and registered outputs.
// Every grant handover passes through IDLE, so the two grants never overlap.
module bus_arbiter #(
    parameter int unsigned MAX_HOLD = 64,
    parameter int unsigned CNT_W    = 7
) (
    input  logic          clk,
    input  logic          rst,
    bus_arbiter_if.slave  bus
);

    typedef enum logic [1:0] {IDLE, G1, G2} state_t;
    typedef enum logic {M1, M2} owner_t;

    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(MAX_HOLD - 1);

    state_t           state_q, state_d;
    owner_t           last_q, last_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             preempt_d;
    logic             grant_m1_d, grant_m2_d, bus_busy_d, select_d;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q           <= IDLE;
            last_q            <= M2;
            cnt_q             <= '0;
            bus.grant_m1      <= 1'b0;
            bus.grant_m2      <= 1'b0;
            bus.bus_busy      <= 1'b0;
            bus.preempt       <= 1'b0;
            bus.master_select <= 1'b1;
        end else begin
            state_q           <= state_d;
            last_q            <= last_d;
            cnt_q             <= cnt_d;
            bus.grant_m1      <= grant_m1_d;
            bus.grant_m2      <= grant_m2_d;
            bus.bus_busy      <= bus_busy_d;
            bus.preempt       <= preempt_d;
            bus.master_select <= select_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        last_d    = last_q;
        cnt_d     = cnt_q;
        preempt_d = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (bus.req_m1 && bus.req_m2)
                    state_d = (last_q == M2) ? G1 : G2;
                else if (bus.req_m1)
                    state_d = G1;
                else if (bus.req_m2)
                    state_d = G2;
            end
            // A release on the same edge as a timeout wins, so no preempt pulse then.
            G1: begin
                if (!bus.req_m1) begin
                    state_d = IDLE;
                end else if (bus.req_m2 && cnt_q == HOLD_LAST) begin
                    state_d   = IDLE;
                    preempt_d = 1'b1;
                end else if (cnt_q != HOLD_LAST) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            G2: begin
                if (!bus.req_m2) begin
                    state_d = IDLE;
                end else if (bus.req_m1 && cnt_q == HOLD_LAST) begin
                    state_d   = IDLE;
                    preempt_d = 1'b1;
                end else if (cnt_q != HOLD_LAST) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
        if (state_q == IDLE && state_d == G1) begin
            cnt_d  = '0;
            last_d = M1;
        end else if (state_q == IDLE && state_d == G2) begin
            cnt_d  = '0;
            last_d = M2;
        end
    end

    // Output next-values are decoded from the next state so they register with it.
    always_comb begin
        grant_m1_d = (state_d == G1);
        grant_m2_d = (state_d == G2);
        bus_busy_d = (state_d != IDLE);
        select_d   = bus.master_select;
        if (state_d == G1)
            select_d = 1'b1;
        else if (state_d == G2)
            select_d = 1'b0;
    end

endmodule

// File: tb/tb_bus_arbiter.sv
// Directed plus randomized bench for bus_arbiter, checked cycle by cycle
// against a behavioural model of ownership, hold time and round-robin history.
module tb_bus_arbiter;

    localparam int unsigned MAX_HOLD = 8;
    localparam int unsigned CNT_W    = 4;

    logic clk;
    logic rst;

    bus_arbiter_if bus ();

    bus_arbiter #(.MAX_HOLD(MAX_HOLD), .CNT_W(CNT_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int passed = 0;
    int total  = 0;

    // Model: who owns the bus (0 = nobody), how many cycles it has held it,
    // who was granted most recently, and the expected select/preempt values.
    int m_owner;
    int m_held;
    int m_last;
    bit m_sel;
    bit m_pre;

    task automatic model_reset();
        m_owner = 0;
        m_held  = 0;
        m_last  = 2;
        m_sel   = 1'b1;
        m_pre   = 1'b0;
    endtask

    task automatic model_edge(input bit r1, input bit r2);
        bit own_req;
        bit other_req;
        m_pre = 1'b0;
        if (m_owner == 0) begin
            if (r1 && r2)
                m_owner = (m_last == 1) ? 2 : 1;
            else if (r1)
                m_owner = 1;
            else if (r2)
                m_owner = 2;
            if (m_owner != 0) begin
                m_held = 1;
                m_last = m_owner;
                m_sel  = (m_owner == 1);
            end
        end else begin
            own_req   = (m_owner == 1) ? r1 : r2;
            other_req = (m_owner == 1) ? r2 : r1;
            if (!own_req) begin
                m_owner = 0;
            end else if (other_req && m_held >= int'(MAX_HOLD)) begin
                m_owner = 0;
                m_pre   = 1'b1;
            end else begin
                m_held++;
            end
        end
    endtask

    task automatic chk(input string tag, input logic obs, input logic exp);
        total++;
        assert (obs === exp) begin
            passed++;
        end else begin
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, "/grant_m1"},      bus.grant_m1,      logic'(m_owner == 1));
        chk({tag, "/grant_m2"},      bus.grant_m2,      logic'(m_owner == 2));
        chk({tag, "/bus_busy"},      bus.bus_busy,      logic'(m_owner != 0));
        chk({tag, "/master_select"}, bus.master_select, m_sel);
        chk({tag, "/preempt"},       bus.preempt,       m_pre);
    endtask

    // Drive requests, clock one edge, update the model, sample 1 ns later.
    task automatic step(input bit r1, input bit r2, input string tag);
        bus.req_m1 = r1;
        bus.req_m2 = r2;
        @(posedge clk);
        if (rst) model_edge(r1, r2);
        #1;
        check_all(tag);
    endtask

    // Reset asserted between edges: outputs must clear before the next edge.
    task automatic async_reset(input bit r1, input bit r2);
        #2;
        rst = 1'b0;
        #1;
        model_reset();
        check_all("async_rst");
        step(r1, r2, "in_rst");
        #2;
        rst = 1'b1;
    endtask

    int g1_len;
    bit r1, r2;

    initial begin
        rst        = 1'b0;
        bus.req_m1 = 1'b1;
        bus.req_m2 = 1'b1;
        model_reset();

        // Reset held for 3 cycles with both requests active.
        for (int i = 0; i < 3; i++) step(1'b1, 1'b1, "reset");
        #2;
        rst = 1'b1;
        step(1'b1, 1'b1, "first_tie");
        step(1'b0, 1'b0, "first_rel");
        step(1'b0, 1'b0, "idle");

        // Single master 2 for 10 cycles, then release; select must stay 0.
        for (int i = 0; i < 10; i++) step(1'b0, 1'b1, "single_m2");
        for (int i = 0; i < 3; i++)  step(1'b0, 1'b0, "single_idle");

        // Round-robin: each master drops its request after 5 granted cycles.
        for (int i = 0; i < 24; i++) begin
            r1 = !(m_owner == 1 && m_held == 5);
            r2 = !(m_owner == 2 && m_held == 5);
            step(r1, r2, "round_robin");
        end
        step(1'b0, 1'b0, "rr_idle");
        step(1'b0, 1'b0, "rr_idle");

        // Preemption: M1 granted, M2 joins two cycles into the grant.
        step(1'b1, 1'b0, "pre_m1");
        step(1'b1, 1'b0, "pre_m1");
        g1_len = 2;
        for (int i = 0; i < 20; i++) begin
            step(1'b1, 1'b1, "pre_contend");
            if (bus.grant_m1 !== 1'b1) break;
            g1_len++;
        end
        chk("pre_len", logic'(g1_len == int'(MAX_HOLD)), 1'b1);
        chk("pre_pulse", bus.preempt, 1'b1);
        step(1'b0, 1'b1, "pre_m2");
        step(1'b0, 1'b1, "pre_m2");
        step(1'b0, 1'b0, "pre_rel");
        step(1'b0, 1'b0, "pre_idle");

        // Late contender: M1 alone for 20 cycles, then M2 requests.
        for (int i = 0; i < 20; i++) step(1'b1, 1'b0, "late_m1");
        step(1'b1, 1'b1, "late_preempt");
        chk("late_pulse", bus.preempt, 1'b1);
        step(1'b1, 1'b1, "late_g2");
        chk("late_grant_m2", bus.grant_m2, 1'b1);
        step(1'b0, 1'b0, "late_rel");
        step(1'b0, 1'b0, "late_idle");

        // Glitch between edges is never sampled.
        bus.req_m1 = 1'b1;
        #1;
        bus.req_m1 = 1'b0;
        step(1'b0, 1'b0, "glitch");

        // Reset during a G2 grant, then re-enter G2.
        step(1'b0, 1'b1, "mid_g2");
        step(1'b0, 1'b1, "mid_g2");
        async_reset(1'b0, 1'b1);
        step(1'b0, 1'b1, "after_rst_g2");
        chk("after_rst_grant_m2", bus.grant_m2, 1'b1);

        // Random requests with sticky behaviour and occasional mid-cycle reset.
        r1 = 1'b0;
        r2 = 1'b0;
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(3) == 0) r1 = ~r1;
            if ($urandom_range(3) == 0) r2 = ~r2;
            if ($urandom_range(60) == 0)
                async_reset(r1, r2);
            else
                step(r1, r2, "random");
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
